// File: rtl/bt_seq_alu.sv
// bt_seq_alu: sequential balanced-ternary ALU (add, sub, mul, neg).
// Trit codes: 2'b01 = -1, 2'b11 = 0, 2'b10 = +1, 2'b00 is invalid and is
// treated as 0. Add/sub/neg take one RUN cycle. Multiply takes TRITS RUN
// cycles and consumes one multiplier trit per cycle.
// Optional feature macro: BT_INVALID_CHECK_EN adds the err output, which
// flags 2'b00 trits seen in the operands of the current transaction.
module bt_seq_alu #(
    parameter int TRITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [2*TRITS-1:0]   a,
    input  logic [2*TRITS-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*TRITS-1:0]   result
`ifdef BT_INVALID_CHECK_EN
    ,
    output logic                 err
`endif
);

    localparam int W      = 2 * TRITS;   // operand width in bits
    localparam int RW     = 4 * TRITS;   // result width in bits
    localparam int RT     = 2 * TRITS;   // result width in trits
    localparam int STEP_W = (TRITS > 1) ? $clog2(TRITS) : 1;

    localparam logic [RW-1:0]     ZERO      = {RT{2'b11}};
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TRITS - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_NEG = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic [1:0]          op_reg;
    logic [RW-1:0]       acc_reg;
    logic [RW-1:0]       result_reg;
    logic [STEP_W-1:0]   step_reg;
    logic                out_valid_reg;

    logic [W-1:0]        a_neg;
    logic [W-1:0]        b_neg;
    logic [1:0]          b_trit;
    logic [W-1:0]        pp;
    logic [RW-1:0]       add_x;
    logic [RW-1:0]       add_y;
    logic [RW-1:0]       add_sum;

    // Decode a trit code to its value; 00 and 11 both read as zero.
    function automatic logic signed [3:0] trit_val(input logic [1:0] c);
        case (c)
            2'b01:   trit_val = -4'sd1;
            2'b10:   trit_val = 4'sd1;
            default: trit_val = 4'sd0;
        endcase
    endfunction

    // Encode a digit in -1..+1 back to its canonical code.
    function automatic logic [1:0] trit_enc(input logic signed [3:0] v);
        case (v)
            -4'sd1:  trit_enc = 2'b01;
            4'sd1:   trit_enc = 2'b10;
            default: trit_enc = 2'b11;
        endcase
    endfunction

    // Ripple balanced-ternary add over the full result width. The final
    // carry is dropped: every caller keeps the true sum inside RT trits.
    function automatic logic [RW-1:0] bt_add(input logic [RW-1:0] x,
                                             input logic [RW-1:0] y);
        logic signed [3:0] carry;
        logic signed [3:0] s;
        logic [RW-1:0]     sum;
        carry = 4'sd0;
        sum   = ZERO;
        for (int i = 0; i < RT; i++) begin
            s = trit_val(x[2*i +: 2]) + trit_val(y[2*i +: 2]) + carry;
            if (s > 4'sd1) begin
                s     = s - 4'sd3;
                carry = 4'sd1;
            end else if (s < -4'sd1) begin
                s     = s + 4'sd3;
                carry = -4'sd1;
            end else begin
                carry = 4'sd0;
            end
            sum[2*i +: 2] = trit_enc(s);
        end
        return sum;
    endfunction

    // Negation swaps 01 and 10 in each trit, i.e. reverses each bit pair.
    for (genvar gi = 0; gi < TRITS; gi++) begin : gen_neg
        assign a_neg[2*gi +: 2] = {a_reg[2*gi], a_reg[2*gi+1]};
        assign b_neg[2*gi +: 2] = {b_reg[2*gi], b_reg[2*gi+1]};
    end

    // Select the adder operands for the registered op and the current step.
    always_comb begin
        b_trit = b_reg[{step_reg, 1'b0} +: 2];
        case (b_trit)
            2'b10:   pp = a_reg;
            2'b01:   pp = a_neg;
            default: pp = '0;
        endcase
        add_x = ZERO;
        add_y = ZERO;
        case (op_reg)
            OP_ADD: begin
                add_x = {{W{1'b0}}, a_reg};
                add_y = {{W{1'b0}}, b_reg};
            end
            OP_SUB: begin
                add_x = {{W{1'b0}}, a_reg};
                add_y = {{W{1'b0}}, b_neg};
            end
            OP_MUL: begin
                // Zero bits shifted in are 00 codes, which read as zero.
                add_x = acc_reg;
                add_y = {{W{1'b0}}, pp} << {step_reg, 1'b0};
            end
            default: begin
                add_x = ZERO;
                add_y = {{W{1'b0}}, a_neg};
            end
        endcase
        add_sum = bt_add(add_x, add_y);
    end

`ifdef BT_INVALID_CHECK_EN
    logic [TRITS-1:0] a_bad;
    logic [TRITS-1:0] b_bad;
    logic             operand_bad;
    logic             err_reg;

    for (genvar gi = 0; gi < TRITS; gi++) begin : gen_chk
        assign a_bad[gi] = (a[2*gi +: 2] == 2'b00);
        assign b_bad[gi] = (b[2*gi +: 2] == 2'b00);
    end

    assign operand_bad = (|a_bad) || ((op != OP_NEG) && (|b_bad));

    // Capture the operand check on each accept; held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (state_reg == IDLE && in_valid) begin
            err_reg <= operand_bad;
        end
    end

    assign err = err_reg;
`endif

    // Control FSM with operand capture, multiply accumulation and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= OP_ADD;
            acc_reg       <= ZERO;
            result_reg    <= ZERO;
            step_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        op_reg    <= op;
                        acc_reg   <= ZERO;
                        step_reg  <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (op_reg == OP_MUL) begin
                        acc_reg <= add_sum;
                        if (step_reg == LAST_STEP) begin
                            result_reg    <= add_sum;
                            out_valid_reg <= 1'b1;
                            step_reg      <= '0;
                            state_reg     <= DONE;
                        end else begin
                            step_reg <= step_reg + 1'b1;
                        end
                    end else begin
                        result_reg    <= add_sum;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_bt_seq_alu.sv
// Testbench for bt_seq_alu with TRITS=4: table of directed vectors plus
// hand-written back-pressure, reset-mid-multiply and invalid-code sequences.
module tb_bt_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
`ifdef BT_INVALID_CHECK_EN
    logic        err;
`endif

    int total = 0;
    int bad   = 0;

    bt_seq_alu #(.TRITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef BT_INVALID_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        int         av;
        int         bv;
        int         expv;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    // Balanced-ternary encoding of an integer into 8 trits.
    function automatic logic [15:0] to_bt(input int v);
        logic [15:0] r;
        int x;
        int m;
        x = v;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            m = ((x % 3) + 3) % 3;
            if (m == 0) begin
                r[2*i +: 2] = 2'b11;
                x = x / 3;
            end else if (m == 1) begin
                r[2*i +: 2] = 2'b10;
                x = (x - 1) / 3;
            end else begin
                r[2*i +: 2] = 2'b01;
                x = (x + 1) / 3;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Launch one op and wait (bounded) for out_valid; lat counts edges after accept.
    task automatic run_op(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                          output logic [15:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        op = o;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        $display("op=%0d a=%h b=%h -> result=%h lat=%0d", o, av, bv, res, lat);
    endtask

    initial begin
        logic [15:0] res;
        logic [15:0] held;
        logic [15:0] tmp_a;
        logic [15:0] tmp_b;
        int lat;

        vecs[0]  = '{2'b00,  40,   1,    41, 1};
        vecs[1]  = '{2'b01,   5,   7,    -2, 1};
        vecs[2]  = '{2'b11,  13,   0,   -13, 1};
        vecs[3]  = '{2'b00, -40, -40,   -80, 1};
        vecs[4]  = '{2'b01, -40,  40,   -80, 1};
        vecs[5]  = '{2'b10,  40,  40,  1600, 4};
        vecs[6]  = '{2'b10, -13,   7,   -91, 4};
        vecs[7]  = '{2'b10,   0,  29,     0, 4};
        vecs[8]  = '{2'b10, -40,  40, -1600, 4};
        vecs[9]  = '{2'b10,   1,  -1,    -1, 4};
        vecs[10] = '{2'b00,   0,   0,     0, 1};
        vecs[11] = '{2'b11, -40,  17,    40, 1};

        rst = 1'b1;
        in_valid = 1'b0;
        op = 2'b00;
        a = 8'hFF;
        b = 8'hFF;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", {16'b0, result}, 32'h0000FFFF);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
`ifdef BT_INVALID_CHECK_EN
        chk("reset_err", {31'b0, err}, 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);

        // Table-driven vectors with out_ready held high.
        for (int i = 0; i < 12; i++) begin
            tmp_a = to_bt(vecs[i].av);
            tmp_b = to_bt(vecs[i].bv);
            run_op(vecs[i].op, tmp_a[7:0], tmp_b[7:0], res, lat);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_result", i), {16'b0, res}, {16'b0, to_bt(vecs[i].expv)});
            if (i == 0)
                chk("add_40_1_literal", {16'b0, res}, 32'h0000FE55);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_handshake_valid", i), {31'b0, out_valid}, 32'd0);
            chk($sformatf("vec%0d_next_ready", i), {31'b0, in_ready}, 32'd1);
        end

        // Back-pressure: result held and no new accept while out_ready is low.
        out_ready = 1'b0;
        tmp_a = to_bt(13);
        tmp_b = to_bt(-13);
        run_op(2'b10, tmp_a[7:0], tmp_b[7:0], held, lat);
        chk("bp_latency", lat, 32'd4);
        chk("bp_result", {16'b0, held}, {16'b0, to_bt(-169)});
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("bp_stall%0d_valid", c), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp_stall%0d_result", c), {16'b0, result}, {16'b0, to_bt(-169)});
            chk($sformatf("bp_stall%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_release_result", {16'b0, result}, {16'b0, to_bt(-169)});

        // Reset asserted while the multiply sits at step 2, in_valid high.
        tmp_a = to_bt(40);
        tmp_b = to_bt(40);
        op = 2'b10;
        a = tmp_a[7:0];
        b = tmp_b[7:0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_result", {16'b0, result}, 32'h0000FFFF);
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_out_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_release_in_ready", {31'b0, in_ready}, 32'd1);
        tmp_a = to_bt(-13);
        tmp_b = to_bt(7);
        run_op(2'b10, tmp_a[7:0], tmp_b[7:0], res, lat);
        chk("post_rst_latency", lat, 32'd4);
        chk("post_rst_result", {16'b0, res}, {16'b0, to_bt(-91)});
        @(posedge clk); #1;

`ifdef BT_INVALID_CHECK_EN
        // Invalid code in a: op completes with 00 read as zero, err raised.
        run_op(2'b00, 8'b11_00_11_10, 8'hFF, res, lat);
        chk("inv_result", {16'b0, res}, {16'b0, to_bt(1)});
        chk("inv_err", {31'b0, err}, 32'd1);
        @(posedge clk); #1;
        tmp_a = to_bt(1);
        run_op(2'b00, tmp_a[7:0], tmp_a[7:0], res, lat);
        chk("clean_result", {16'b0, res}, {16'b0, to_bt(2)});
        chk("clean_err", {31'b0, err}, 32'd0);
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
